// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//
// Sits on the fast PLL output clock. It pulses the PLL reset, waits for the
// PLL to report lock, and requires lock to stay high without a break before
// it releases the core reset. While the core runs, the block produces the
// pixel and CPU clock enables. A lost lock, or a lock that never arrives,
// sends the sequence back to a fresh PLL reset pulse.
//
// Ports
//   clk_sys        in   fast PLL output clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   pll_locked     in   PLL lock flag, asynchronous to clk_sys
//   pll_rst        out  reset request to the PLL, active high
//   sys_reset      out  core reset, active high, low only in RUN
//   ce_pix         out  one-cycle pixel clock enable, period PIX_DIV
//   ce_cpu         out  one-cycle CPU clock enable, period CPU_DIV
//   lock_lost_cnt  out  saturating count of lock losses seen in RUN
//   seq_state      out  0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN
//
// There is no valid/ready handshake. Every output is a plain registered level
// or a single-cycle pulse.

module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int PIX_DIV        = 16,
    parameter int CPU_DIV        = 32
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ce_pix,
    output logic       ce_cpu,
    output logic [7:0] lock_lost_cnt,
    output logic [1:0] seq_state
);

    // The shared timer must be able to hold the largest terminal count.
    localparam int T_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > STABLE_CYCLES) ? T_MAX_A : STABLE_CYCLES;
    localparam int TW      = $clog2(T_MAX);
    localparam int PW      = $clog2(PIX_DIV);
    localparam int CW      = $clog2(CPU_DIV);

    localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
    localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIV - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] cpu_cnt;
    logic          lock_sync1;
    logic          lk;
    logic          lost;
    logic          stay_run;

    // Two-flop synchroniser. Only lk is used past this point.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync1 <= 1'b0;
            lk         <= 1'b0;
        end else begin
            lock_sync1 <= pll_locked;
            lk         <= lock_sync1;
        end
    end

    always_comb begin
        next_state = state;
        lost       = 1'b0;
        unique case (state)
            S_PLL_RST: begin
                if (timer == RST_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk)                   next_state = S_STABLE;
                else if (timer == TO_LAST) next_state = S_PLL_RST;
            end
            S_STABLE: begin
                // A drop in lock wins over the stable-time expiry in the same cycle.
                if (!lk)                    next_state = S_WAIT_LOCK;
                else if (timer == STB_LAST) next_state = S_RUN;
            end
            S_RUN: begin
                if (!lk) begin
                    next_state = S_PLL_RST;
                    lost       = 1'b1;
                end
            end
            default: next_state = S_PLL_RST;
        endcase
    end

    // Enables fire only when RUN continues into the next cycle. The cycle
    // after RUN is left therefore never carries a stray pulse.
    assign stay_run = (state == S_RUN) && (next_state == S_RUN);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_PLL_RST;
            timer         <= '0;
            pll_rst       <= 1'b1;
            sys_reset     <= 1'b1;
            ce_pix        <= 1'b0;
            ce_cpu        <= 1'b0;
            pix_cnt       <= '0;
            cpu_cnt       <= '0;
            lock_lost_cnt <= 8'd0;
        end else begin
            state <= next_state;

            // The timer restarts on every transition. It stays at zero in RUN.
            if ((next_state != state) || (state == S_RUN)) timer <= '0;
            else                                           timer <= timer + 1'b1;

            pll_rst   <= (next_state == S_PLL_RST);
            sys_reset <= (next_state != S_RUN);

            // The counters start together from 0 on RUN entry. A pulse appears one
            // cycle after a counter reaches DIV-1, so the first enable comes DIV
            // cycles into RUN.
            if (stay_run) begin
                pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + 1'b1;
            end else begin
                pix_cnt <= '0;
                cpu_cnt <= '0;
            end
            ce_pix <= stay_run && (pix_cnt == PIX_LAST);
            ce_cpu <= stay_run && (cpu_cnt == CPU_LAST);

            if (lost && (lock_lost_cnt != 8'hFF)) lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//
// Testbench for pll_lock_sequencer. Each scenario first builds the pll_locked
// waveform as one value per cycle. A reference model then scans that waveform
// phase by phase and queues the expected state changes and clock-enable
// pulses. A monitor process pops and compares an entry whenever the DUT
// changes state or raises an enable. The bench uses shortened timeout and
// stable windows so that the long loss sequences stay brief.
//
// Cycle numbering: cycle 0 is the interval that starts when rst_n is
// released. The bench applies pin[t] during cycle t. Two synchroniser stages
// delay the pin, so the sequencer sees pin[t-2] in cycle t.

module tb_pll_lock_sequencer;

    localparam int RST_C = 16;
    localparam int TO_C  = 256;
    localparam int STB_C = 64;
    localparam int PIX_C = 16;
    localparam int CPU_C = 32;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ce_pix;
    logic       ce_cpu;
    logic [7:0] lock_lost_cnt;
    logic [1:0] seq_state;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (STB_C),
        .PIX_DIV       (PIX_C),
        .CPU_DIV       (CPU_C)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_reset    (sys_reset),
        .ce_pix       (ce_pix),
        .ce_cpu       (ce_cpu),
        .lock_lost_cnt(lock_lost_cnt),
        .seq_state    (seq_state)
    );

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- bench state ----------------
    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    bit          pin[$];
    logic [43:0] exp_q[$];   // {cycle, state, lost count, sys_reset, pll_rst}
    logic [33:0] ce_q[$];    // {cycle, ce_pix, ce_cpu}
    logic [7:0]  m_llc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit lk_at(input int t);
        return (t >= 2) ? pin[t-2] : 1'b0;
    endfunction

    function automatic logic [43:0] pack_evt(input int c, input logic [1:0] s, input logic [7:0] l);
        return {c[31:0], s, l, (s != 2'd3), (s == 2'd0)};
    endfunction

    task automatic add(input bit v, input int len);
        repeat (len) pin.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Walk the waveform one phase at a time. For each phase, find the cycle
    // that ends it according to the phase's rule.
    task automatic run_model();
        int         n;
        int         t;
        int         nt;
        int         u;
        int         limit;
        bit         found;
        logic [1:0] s;
        logic [1:0] ns;
        logic [7:0] llc;
        n   = pin.size();
        t   = 0;
        s   = 2'd0;
        llc = 8'd0;
        exp_q.delete();
        ce_q.delete();
        while (t < n) begin
            case (s)
                2'd0: begin
                    nt = t + RST_C;
                    ns = 2'd1;
                end
                2'd1: begin
                    nt = t + TO_C;
                    ns = 2'd0;
                    for (u = t; u < t + TO_C && u < n; u++)
                        if (lk_at(u)) begin nt = u + 1; ns = 2'd2; break; end
                end
                2'd2: begin
                    nt = t + STB_C;
                    ns = 2'd3;
                    for (u = t; u < t + STB_C && u < n; u++)
                        if (!lk_at(u)) begin nt = u + 1; ns = 2'd1; break; end
                end
                default: begin
                    found = 1'b0;
                    nt    = n;
                    ns    = 2'd0;
                    for (u = t; u < n; u++)
                        if (!lk_at(u)) begin found = 1'b1; break; end
                    limit = found ? u : n - 1;
                    for (int c = t + PIX_C; c <= limit; c += PIX_C)
                        ce_q.push_back({c[31:0], 1'b1, (((c - t) % CPU_C) == 0)});
                    if (found) begin
                        nt = u + 1;
                        if (llc != 8'hFF) llc = llc + 8'd1;
                    end
                end
            endcase
            if (nt < n) exp_q.push_back(pack_evt(nt, ns, llc));
            t = nt;
            s = ns;
        end
        m_llc = llc;
    endtask

    // ---------------- monitor ----------------
    task automatic monitor();
        logic [1:0]  prev;
        logic [43:0] a;
        logic [43:0] e;
        logic [33:0] ca;
        logic [33:0] ce_e;
        prev = 2'd0;
        forever begin
            @(negedge clk_sys);
            if (!mon_en) begin
                prev = 2'd0;
            end else begin
                if (seq_state !== prev) begin
                    a = {cyc[31:0], seq_state, lock_lost_cnt, sys_reset, pll_rst};
                    n_total++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL state_evt: unexpected change to st=%0d at cyc=%0d", seq_state, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            n_bad++;
                            $display("FAIL state_evt: got cyc=%0d st=%0d llc=%0d sys=%0b pll=%0b expected cyc=%0d st=%0d llc=%0d sys=%0b pll=%0b",
                                     a[43:12], a[11:10], a[9:2], a[1], a[0],
                                     e[43:12], e[11:10], e[9:2], e[1], e[0]);
                        end
                    end
                    prev = seq_state;
                end
                if (ce_pix || ce_cpu) begin
                    ca = {cyc[31:0], ce_pix, ce_cpu};
                    n_total++;
                    if (ce_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL ce_evt: unexpected pix=%0b cpu=%0b at cyc=%0d", ce_pix, ce_cpu, cyc);
                    end else begin
                        ce_e = ce_q.pop_front();
                        if (ca !== ce_e) begin
                            n_bad++;
                            $display("FAIL ce_evt: got cyc=%0d pix=%0b cpu=%0b expected cyc=%0d pix=%0b cpu=%0b",
                                     ca[33:2], ca[1], ca[0], ce_e[33:2], ce_e[1], ce_e[0]);
                        end
                    end
                end
                // Outputs must agree with the current state in every cycle.
                check("out_decode", {pll_rst, sys_reset}, {(seq_state == 2'd0), (seq_state != 2'd3)});
            end
        end
    endtask

    // ---------------- driver: reset, then play the waveform ----------------
    task automatic play();
        int n;
        n = pin.size();
        run_model();
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk_sys);
        #2;
        rst_n      = 1'b1;
        cyc        = 0;
        pll_locked = pin[0];
        #1;
        check("rst_state", seq_state, 2'd0);
        check("rst_pll_rst", pll_rst, 1'b1);
        check("rst_sys_reset", sys_reset, 1'b1);
        check("rst_llc", lock_lost_cnt, 8'd0);
        check("rst_ce", {ce_pix, ce_cpu}, 2'b00);
        mon_en = 1'b1;
        for (int t = 1; t < n; t++) begin
            @(posedge clk_sys);
            #1;
            cyc        = t;
            pll_locked = pin[t];
        end
        @(negedge clk_sys);
        #1;
        mon_en = 1'b0;
        check("exp_q_drained", exp_q.size(), 0);
        check("ce_q_drained", ce_q.size(), 0);
        check("final_llc", lock_lost_cnt, m_llc);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        fork
            monitor();
        join_none

        // Lock tied high: the full release path and the enable cadence.
        pin.delete();
        add(1'b1, 300);
        play();

        // Lock held low: repeated timeouts. Lock then arrives in the last timer cycle.
        pin.delete();
        add(1'b0, 813);
        add(1'b1, 87);
        play();

        // Drop during STABLE. A single-cycle drop then lands on the expiry cycle.
        pin.delete();
        add(1'b1, 45);
        add(1'b0, 5);
        add(1'b1, 64);
        add(1'b0, 1);
        add(1'b1, 185);
        play();

        // Three-cycle drop in RUN, followed by a full re-sequence.
        pin.delete();
        add(1'b1, 150);
        add(1'b0, 3);
        add(1'b1, 247);
        play();
        check("run_drop_llc", lock_lost_cnt, 8'd1);

        // Random segments: short glitches, medium runs and long gaps.
        pin.delete();
        begin
            bit v;
            int r;
            v = 1'b1;
            while (pin.size() < 6000) begin
                r = $urandom_range(0, 9);
                if (r < 5)      add(v, $urandom_range(1, 6));
                else if (r < 8) add(v, $urandom_range(20, 150));
                else            add(v, $urandom_range(200, 400));
                v = ~v;
            end
        end
        play();

        // 300 losses in RUN: the counter stops at 255.
        pin.delete();
        repeat (300) begin
            add(1'b1, 90 + $urandom_range(0, 40));
            add(1'b0, $urandom_range(2, 4));
        end
        add(1'b1, 100);
        play();
        check("sat_llc", lock_lost_cnt, 8'd255);

        // Seven losses, then rst_n asserted in RUN away from any clock edge.
        pin.delete();
        add(1'b1, 100);
        repeat (7) begin
            add(1'b0, 3);
            add(1'b1, 100);
        end
        add(1'b1, 50);
        play();
        check("pre_async_state", seq_state, 2'd3);
        check("pre_async_llc", lock_lost_cnt, 8'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_state", seq_state, 2'd0);
        check("async_pll_rst", pll_rst, 1'b1);
        check("async_sys_reset", sys_reset, 1'b1);
        check("async_llc", lock_lost_cnt, 8'd0);
        check("async_ce", {ce_pix, ce_cpu}, 2'b00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
